light_phase_sequencer: RTL

LIGHT_PHASE_SEQUENCER -- requirements
Module: light_phase_sequencer

---
 rtl/light_pkg.sv | 40 ++++
 rtl/light_phase_sequencer_if.sv | 25 ++
 rtl/sec_prescaler.sv | 30 +++
 rtl/light_phase_sequencer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// Shared encodings for the traffic-light phase sequencer.
package light_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10,
    ST_RED    = 2'b11
  } state_t;

  localparam logic [1:0] SEL_GREEN  = 2'b00;
  localparam logic [1:0] SEL_YELLOW = 2'b01;
  localparam logic [1:0] SEL_RED    = 2'b10;
  localparam logic [1:0] SEL_RSVD   = 2'b11;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  localparam logic [6:0] MAX_SEC = 7'd99;

  // Running-phase rotation; IDLE always enters GREEN.
  function automatic state_t next_phase(input state_t s);
    case (s)
      ST_GREEN:  return ST_YELLOW;
      ST_YELLOW: return ST_RED;
      default:   return ST_GREEN;
    endcase
  endfunction

  // IDLE shows the red lamp, same as RED.
  function automatic logic [2:0] lamp_of(input state_t s);
    case (s)
      ST_GREEN:  return LAMP_GREEN;
      ST_YELLOW: return LAMP_YELLOW;
      default:   return LAMP_RED;
    endcase
  endfunction

endpackage

// File: rtl/light_phase_sequencer_if.sv
// Control/status bundle of the phase sequencer (everything except clock/reset).
interface light_phase_sequencer_if;
  logic       start;
  logic       mode;
  logic       advance;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [6:0] cfg_value;
  logic [2:0] light;
  logic [6:0] remaining;
  logic       phase_done;
  logic       cfg_err;

  // Controller side: drives requests and configuration, observes status.
  modport master (
    output start, mode, advance, cfg_we, cfg_sel, cfg_value,
    input  light, remaining, phase_done, cfg_err
  );

  // Sequencer side.
  modport slave (
    input  start, mode, advance, cfg_we, cfg_sel, cfg_value,
    output light, remaining, phase_done, cfg_err
  );
endinterface

// File: rtl/sec_prescaler.sv
// One-second tick generator: tick is high for one cycle every CLK_DIV cycles,
// counting restarts from 0 whenever clear is asserted.
module sec_prescaler #(
  parameter int unsigned CLK_DIV = 50000000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Terminal-count detect and wrap/clear of the cycle counter.
  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/light_phase_sequencer.sv
// Traffic-light phase sequencer: IDLE/GREEN/YELLOW/RED with programmable
// per-phase durations, auto (timed) and manual (advance-only) modes.
module light_phase_sequencer
  import light_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 50000000,
  parameter int unsigned DEF_GREEN  = 30,
  parameter int unsigned DEF_YELLOW = 3,
  parameter int unsigned DEF_RED    = 20
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       mode,
  input  logic       advance,
  input  logic       cfg_we,
  input  logic [1:0] cfg_sel,
  input  logic [6:0] cfg_value,
  output logic [2:0] light,
  output logic [6:0] remaining,
  output logic       phase_done,
  output logic       cfg_err
);

  state_t     state_q, state_d;
  logic [6:0] rem_q, rem_d;
  logic [2:0] light_q, light_d;
  logic       phase_done_q, phase_done_d;
  logic       cfg_err_q, cfg_err_d;
  logic [6:0] dur_green_q, dur_green_d;
  logic [6:0] dur_yellow_q, dur_yellow_d;
  logic [6:0] dur_red_q, dur_red_d;
  logic       cfg_ok;
  logic       tick;
  logic       clear;
  logic       go;

  sec_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clear    (clear),
    .tick     (tick)
  );

  // Duration register file: validate writes, flag rejects one cycle later.
  always_comb begin
    cfg_ok       = cfg_we && (cfg_sel != SEL_RSVD) &&
                   (cfg_value != 7'd0) && (cfg_value <= MAX_SEC);
    cfg_err_d    = cfg_we && !cfg_ok;
    dur_green_d  = dur_green_q;
    dur_yellow_d = dur_yellow_q;
    dur_red_d    = dur_red_q;
    if (cfg_ok) begin
      case (cfg_sel)
        SEL_GREEN:  dur_green_d  = cfg_value;
        SEL_YELLOW: dur_yellow_d = cfg_value;
        default:    dur_red_d    = cfg_value;
      endcase
    end
  end

  // Phase FSM next state, remaining-seconds countdown and registered outputs.
  // Durations are read from the *_d values so a write coinciding with phase
  // entry is the one loaded. Advance and an expiring tick share one 'go'.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    go      = 1'b0;
    if (!start) begin
      state_d = ST_IDLE;
      rem_d   = '0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_GREEN;
    end else begin
      go = advance || (!mode && tick && (rem_q <= 7'd1));
      if (go)                state_d = next_phase(state_q);
      else if (!mode && tick) rem_d  = rem_q - 7'd1;
    end
    if (start && (state_d != state_q)) begin
      case (state_d)
        ST_GREEN:  rem_d = dur_green_d;
        ST_YELLOW: rem_d = dur_yellow_d;
        default:   rem_d = dur_red_d;
      endcase
    end
    clear        = (state_d != state_q) || (state_q == ST_IDLE);
    light_d      = lamp_of(state_d);
    phase_done_d = (state_q != ST_IDLE) && (state_d != ST_IDLE) &&
                   (state_d != state_q);
  end

  // State, duration and output registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      light_q      <= LAMP_RED;
      phase_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      dur_green_q  <= 7'(DEF_GREEN);
      dur_yellow_q <= 7'(DEF_YELLOW);
      dur_red_q    <= 7'(DEF_RED);
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      light_q      <= light_d;
      phase_done_q <= phase_done_d;
      cfg_err_q    <= cfg_err_d;
      dur_green_q  <= dur_green_d;
      dur_yellow_q <= dur_yellow_d;
      dur_red_q    <= dur_red_d;
    end
  end

  assign light      = light_q;
  assign remaining  = rem_q;
  assign phase_done = phase_done_q;
  assign cfg_err    = cfg_err_q;

endmodule
